// File: rtl/noc_link_mux_pkg.sv
// rtl/noc_link_mux_pkg.sv - shared constant functions for the NoC output-link mux
package noc_link_mux_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/noc_rr_arb.sv
// rtl/noc_rr_arb.sv - combinational round-robin arbiter, one-hot grant
// Grants the first requesting channel at or after ptr, wrapping modulo CHANNELS.
module noc_rr_arb
  import noc_link_mux_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int CH_W     = (CHANNELS > 1) ? clog2(CHANNELS) : 1
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [CH_W-1:0]     ptr,
  output logic [CHANNELS-1:0] gnt
);

  function automatic int wrap_idx(input int x);
    return (x >= CHANNELS) ? x - CHANNELS : x;
  endfunction

  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int off = 0; off < CHANNELS; off++) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (!found && req[c] && (c == wrap_idx(int'(ptr) + off))) begin
          gnt[c] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/noc_link_mux.sv
// rtl/noc_link_mux.sv - packet-atomic round-robin merge of virtual channels onto one registered link
// One-entry output register; a channel stays locked from its first flit until its last is accepted.
module noc_link_mux
  import noc_link_mux_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int FLIT_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [CHANNELS-1:0][FLIT_WIDTH-1:0]  in_flit,
  input  logic [CHANNELS-1:0]                  in_last,
  input  logic [CHANNELS-1:0]                  in_valid,
  output logic [CHANNELS-1:0]                  in_ready,
  output logic [FLIT_WIDTH-1:0]                out_flit,
  output logic                                 out_last,
  output logic [CHANNELS-1:0]                  out_valid,
  input  logic [CHANNELS-1:0]                  out_ready
);

  localparam int CH_W = (CHANNELS > 1) ? clog2(CHANNELS) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

  logic                  locked_q, locked_d;
  logic [CH_W-1:0]       lock_ch_q, lock_ch_d;
  logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                  full_q, full_d;
  logic [FLIT_WIDTH-1:0] flit_q, flit_d;
  logic                  last_q, last_d;
  logic [CH_W-1:0]       ch_q, ch_d;

  logic [CHANNELS-1:0]   gnt_rr, gnt_lock, gnt, ch_onehot;
  logic                  drain, space, accept;
  logic [CH_W-1:0]       g_idx;
  logic                  g_last;
  logic [FLIT_WIDTH-1:0] g_flit;

  noc_rr_arb #(
    .CHANNELS (CHANNELS),
    .CH_W     (CH_W)
  ) u_arb (
    .req (in_valid),
    .ptr (rr_ptr_q),
    .gnt (gnt_rr)
  );

  always_comb begin
    ch_onehot = '0;
    gnt_lock  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      ch_onehot[c] = (CH_W'(c) == ch_q);
      gnt_lock[c]  = (CH_W'(c) == lock_ch_q) & in_valid[c];
    end
  end

  assign drain  = full_q & (|(ch_onehot & out_ready));
  assign space  = ~full_q | drain;
  assign gnt    = locked_q ? gnt_lock : gnt_rr;
  assign accept = space & (|gnt);

  // Reset gating stays on the port only, so internal accept never depends on rst_n.
  assign in_ready = (rst_n & space) ? gnt : '0;

  always_comb begin
    g_idx  = '0;
    g_last = 1'b0;
    g_flit = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (gnt[c]) begin
        g_idx  = CH_W'(c);
        g_last = in_last[c];
        g_flit = in_flit[c];
      end
    end
  end

  always_comb begin
    locked_d  = locked_q;
    lock_ch_d = lock_ch_q;
    rr_ptr_d  = rr_ptr_q;
    full_d    = full_q;
    flit_d    = flit_q;
    last_d    = last_q;
    ch_d      = ch_q;
    if (accept) begin
      full_d = 1'b1;
      flit_d = g_flit;
      last_d = g_last;
      ch_d   = g_idx;
      if (g_last) begin
        locked_d = 1'b0;
        rr_ptr_d = (g_idx == LAST_CH) ? '0 : g_idx + CH_W'(1);
      end else begin
        locked_d  = 1'b1;
        lock_ch_d = g_idx;
      end
    end else if (drain) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_q  <= 1'b0;
      lock_ch_q <= '0;
      rr_ptr_q  <= '0;
      full_q    <= 1'b0;
      flit_q    <= '0;
      last_q    <= 1'b0;
      ch_q      <= '0;
    end else begin
      locked_q  <= locked_d;
      lock_ch_q <= lock_ch_d;
      rr_ptr_q  <= rr_ptr_d;
      full_q    <= full_d;
      flit_q    <= flit_d;
      last_q    <= last_d;
      ch_q      <= ch_d;
    end
  end

  assign out_flit  = flit_q;
  assign out_last  = last_q;
  assign out_valid = full_q ? ch_onehot : '0;

endmodule

// File: tb/tb_noc_link_mux.sv
// tb/tb_noc_link_mux.sv - directed self-checking bench for noc_link_mux
module tb_noc_link_mux;

  logic             clk;
  logic             rst_n;
  logic [1:0][31:0] in_flit;
  logic [1:0]       in_last;
  logic [1:0]       in_valid;
  logic [1:0]       in_ready;
  logic [31:0]      out_flit;
  logic             out_last;
  logic [1:0]       out_valid;
  logic [1:0]       out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  noc_link_mux #(.CHANNELS(2), .FLIT_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_flit   (in_flit),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_flit  (out_flit),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] l,
                       input logic [31:0] f0, input logic [31:0] f1);
    in_valid   = v;
    in_last    = l;
    in_flit[0] = f0;
    in_flit[1] = f1;
  endtask

  task automatic go_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic go_neg();
    @(negedge clk);
  endtask

  task automatic check_out(input string tag, input logic [1:0] v,
                           input logic [31:0] f, input logic l);
    check_eq({tag, ".valid"}, 64'(out_valid), 64'(v));
    if (v != 2'b00) begin
      check_eq({tag, ".flit"}, 64'(out_flit), 64'(f));
      check_eq({tag, ".last"}, 64'(out_last), 64'(l));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 2'b11;
    drive(2'b11, 2'b00, 32'h0, 32'h0);

    // reset state
    go_neg();
    check_eq("rst.in_ready", 64'(in_ready), 64'h0);
    check_eq("rst.out_valid", 64'(out_valid), 64'h0);
    check_eq("rst.out_flit", 64'(out_flit), 64'h0);
    check_eq("rst.out_last", 64'(out_last), 64'h0);
    go_pos();
    drive(2'b00, 2'b00, 32'h0, 32'h0);
    rst_n = 1'b1;
    check_eq("rst.rr_ptr", 64'(dut.rr_ptr_q), 64'h0);

    // single channel, 3-flit packet on ch0
    drive(2'b01, 2'b00, 32'hA1, 32'h0);
    go_neg(); check_eq("t1.rdy0", 64'(in_ready), 64'h1);
    check_eq("t1.empty", 64'(out_valid), 64'h0);
    go_pos();
    drive(2'b01, 2'b00, 32'hA2, 32'h0);
    go_neg(); check_eq("t1.rdy1", 64'(in_ready), 64'h1);
    check_out("t1.o1", 2'b01, 32'hA1, 1'b0);
    go_pos();
    drive(2'b01, 2'b01, 32'hA3, 32'h0);
    go_neg(); check_out("t1.o2", 2'b01, 32'hA2, 1'b0);
    go_pos();
    drive(2'b00, 2'b00, 32'h0, 32'h0);
    go_neg(); check_out("t1.o3", 2'b01, 32'hA3, 1'b1);
    check_eq("t1.rr_ptr", 64'(dut.rr_ptr_q), 64'h1);
    go_pos();
    go_neg(); check_eq("t1.drained", 64'(out_valid), 64'h0);
    go_pos();

    // single flit on ch1 wraps the pointer back to 0
    drive(2'b10, 2'b10, 32'h0, 32'hB0);
    go_neg(); check_eq("wrap.rdy", 64'(in_ready), 64'h2);
    go_pos();
    drive(2'b00, 2'b00, 32'h0, 32'h0);
    go_neg(); check_out("wrap.o", 2'b10, 32'hB0, 1'b1);
    check_eq("wrap.rr_ptr", 64'(dut.rr_ptr_q), 64'h0);
    go_pos();

    // contention: ch0 packet completes before ch1 starts
    drive(2'b11, 2'b00, 32'hC1, 32'hD1);
    go_neg(); check_eq("t2.rdy0", 64'(in_ready), 64'h1);
    go_pos();
    drive(2'b11, 2'b01, 32'hC2, 32'hD1);
    go_neg(); check_eq("t2.rdy1_locked", 64'(in_ready), 64'h1);
    check_out("t2.o1", 2'b01, 32'hC1, 1'b0);
    go_pos();
    drive(2'b10, 2'b00, 32'h0, 32'hD1);
    go_neg(); check_eq("t2.rdy2", 64'(in_ready), 64'h2);
    check_out("t2.o2", 2'b01, 32'hC2, 1'b1);
    go_pos();
    drive(2'b10, 2'b10, 32'h0, 32'hD2);
    go_neg(); check_eq("t2.rdy3", 64'(in_ready), 64'h2);
    check_out("t2.o3", 2'b10, 32'hD1, 1'b0);
    go_pos();
    drive(2'b00, 2'b00, 32'h0, 32'h0);
    go_neg(); check_out("t2.o4", 2'b10, 32'hD2, 1'b1);
    go_pos();

    // fairness: single-flit packets on both channels alternate
    drive(2'b11, 2'b11, 32'hE0, 32'hF0);
    for (int k = 0; k < 4; k++) begin
      go_neg();
      check_eq($sformatf("t3.rdy%0d", k), 64'(in_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
      if (k > 0)
        check_out($sformatf("t3.o%0d", k), (k % 2 == 1) ? 2'b01 : 2'b10,
                  (k % 2 == 1) ? 32'hE0 : 32'hF0, 1'b1);
      go_pos();
    end
    drive(2'b00, 2'b00, 32'h0, 32'h0);
    go_neg(); check_out("t3.o4", 2'b10, 32'hF0, 1'b1);
    go_pos();

    // backpressure on ch0 with the OR full
    drive(2'b01, 2'b01, 32'h61, 32'h0);
    go_pos();
    out_ready = 2'b10;
    drive(2'b01, 2'b01, 32'h62, 32'h0);
    for (int k = 0; k < 4; k++) begin
      go_neg();
      check_eq($sformatf("t4.rdy%0d", k), 64'(in_ready), 64'h0);
      check_out($sformatf("t4.hold%0d", k), 2'b01, 32'h61, 1'b1);
      go_pos();
    end
    out_ready = 2'b11;
    go_neg(); check_eq("t4.rdy_rise", 64'(in_ready), 64'h1);
    go_pos();
    drive(2'b00, 2'b00, 32'h0, 32'h0);
    go_neg(); check_out("t4.next", 2'b01, 32'h62, 1'b1);
    go_pos();

    // bubble inside a locked ch0 packet (pointer is 1 here)
    drive(2'b01, 2'b00, 32'h71, 32'h0);
    go_pos();
    drive(2'b10, 2'b10, 32'h0, 32'h81);
    go_neg(); check_eq("t5.bub0", 64'(in_ready), 64'h0);
    check_out("t5.o1", 2'b01, 32'h71, 1'b0);
    go_pos();
    go_neg(); check_eq("t5.bub1", 64'(in_ready), 64'h0);
    check_eq("t5.empty", 64'(out_valid), 64'h0);
    go_pos();
    drive(2'b11, 2'b11, 32'h72, 32'h81);
    go_neg(); check_eq("t5.resume", 64'(in_ready), 64'h1);
    go_pos();
    drive(2'b10, 2'b10, 32'h0, 32'h81);
    go_neg(); check_eq("t5.ch1", 64'(in_ready), 64'h2);
    check_out("t5.o2", 2'b01, 32'h72, 1'b1);
    go_pos();
    drive(2'b00, 2'b00, 32'h0, 32'h0);
    go_neg(); check_out("t5.o3", 2'b10, 32'h81, 1'b1);
    go_pos();

    // asynchronous reset mid-packet
    drive(2'b01, 2'b00, 32'h91, 32'h0);
    go_pos();
    drive(2'b11, 2'b10, 32'h92, 32'hA5);
    go_neg(); check_out("t6.o1", 2'b01, 32'h91, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6.rst_valid", 64'(out_valid), 64'h0);
    check_eq("t6.rst_flit", 64'(out_flit), 64'h0);
    check_eq("t6.rst_last", 64'(out_last), 64'h0);
    check_eq("t6.rst_ready", 64'(in_ready), 64'h0);
    go_pos();
    drive(2'b10, 2'b10, 32'h0, 32'hA5);
    rst_n = 1'b1;
    go_neg(); check_eq("t6.ch1_wins", 64'(in_ready), 64'h2);
    go_pos();
    drive(2'b00, 2'b00, 32'h0, 32'h0);
    go_neg(); check_out("t6.o2", 2'b10, 32'hA5, 1'b1);
    check_eq("t6.rr_ptr", 64'(dut.rr_ptr_q), 64'h0);
    go_pos();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/noc_link_mux.md
# noc_link_mux

Per-tile output-link multiplexer that sits directly downstream of the compute-tile network adapter's `noc_out_*` channel bundle. It merges `CHANNELS` virtual-channel flit streams onto one registered physical link toward the mesh router. Arbitration is round-robin and packet-atomic: once a packet's first flit wins, the channel is locked until its `last` flit is accepted. Per-channel backpressure from the router is honoured through a one-entry output register.

## Interface
- `CHANNELS`, default 2: number of virtual channels; must be ≥1.
- `FLIT_WIDTH`, default 32: flit payload width.
- `clk` in 1: single clock; the only clock of the block.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_flit` in `[CHANNELS-1:0][FLIT_WIDTH-1:0]`: flits from the network adapter.
- `in_last` in `[CHANNELS-1:0]`: last flit of packet.
- `in_valid` in `[CHANNELS-1:0]`: flit valid.
- `in_ready` out `[CHANNELS-1:0]`: flit accepted when `in_valid[c] & in_ready[c]`.
- `out_flit` out `FLIT_WIDTH`: registered link flit.
- `out_last` out 1: registered last marker.
- `out_valid` out `[CHANNELS-1:0]`: one-hot, identifying the channel of `out_flit`; all-zero when empty.
- `out_ready` in `[CHANNELS-1:0]`: router readiness per channel.

## Operation
- Output register (OR) holds `flit`, `last`, `ch`, `full`. Drain condition: `drain = full & out_ready[ch]`. Space condition: `space = ~full | drain`.
- Lock state machine:
  - IDLE: no channel is locked.
  - LOCKED(c): only channel `c` is eligible.
- Eligibility:
  - IDLE: the eligible set is all `in_valid`; the grant goes to the first set bit at or after `rr_ptr`, wrapping modulo `CHANNELS`.
  - LOCKED(c): the grant is `c` if `in_valid[c]`; otherwise no grant.
- Handshake: `in_ready[g] = space` for the granted `g`; all other bits are 0. `in_ready` is combinational from `in_valid`, `out_ready` and state. There is no combinational path from `in_flit`.
- On accept:
  - OR loads the flit and `ch = g`.
  - If `~in_last[g]`: go to LOCKED(g).
  - If `in_last[g]`: go to IDLE, and set `rr_ptr = (g+1) mod CHANNELS`.
- A single-flit packet never locks and still advances `rr_ptr`.
- Drain without accept clears `full`. Accept and drain in the same cycle keep `full = 1` with new contents.
- LOCKED with `in_valid[c] = 0` (bubble): hold the lock, accept nothing, grant no other channel.
- `CHANNELS = 1`: the pointer is constant 0, and lock behaviour is unchanged.
- Reset mid-packet drops the lock and the OR contents. Upstream is reset together with this block.

## Timing
- Reset values:
  - `out_valid = 0`, `out_flit = 0`, `out_last = 0`.
  - `rr_ptr = 0`, state IDLE, `full = 0`.
  - `in_ready = 0` while `rst_n` is low.
- Latency: 1 cycle from input accept to `out_valid`.
- Throughput: 1 flit/cycle sustained while the router holds `out_ready[ch]` high.
- The OR is stable while `out_valid[ch] & ~out_ready[ch]`: `out_flit`, `out_last` and `out_valid` do not change.
- The arbitration decision takes effect in the accept cycle. The new lock and pointer are visible the next cycle.
- Pointer width: `CH_W = max(1, clog2(CHANNELS))`, incremented with explicit wrap at `CHANNELS-1` (non-power-of-two safe).

## Structure
- Use `clog2` from the shared functions package. No new typedefs; `CH_W` is a localparam.
- Sub-module `noc_rr_arb`: combinational round-robin grant, one-hot output, taking `req[CHANNELS]` and `ptr[CH_W]`.
- The top level holds the OR, lock FSM and pointer register (about 150–220 lines total).

## Test plan
- Reset, then single channel:
  - Stimulus: ch0 sends a 3-flit packet `A1, A2, A3` (last on `A3`) with `out_ready = 11`.
  - Response: `out_valid = 01` for 3 consecutive cycles starting 1 cycle after the first accept; flits in order; `out_last` only with `A3`; `rr_ptr = 1` afterwards.
- Contention:
  - Stimulus: ch0 and ch1 both valid with 2-flit packets, starting from `rr_ptr = 0`.
  - Response: ch0's two flits first, then ch1's; flits are never interleaved; `in_ready[1] = 0` while ch0 is locked.
- Fairness:
  - Stimulus: both channels continuously send single-flit packets.
  - Response: the output alternates `01, 10, 01, 10…`.
- Backpressure:
  - Stimulus: `out_ready[0] = 0` for 4 cycles with the OR full on ch0.
  - Response: the OR is held constant; `in_ready = 00`; the next flit appears 1 cycle after `out_ready[0]` rises.
- Bubble in locked packet:
  - Stimulus: ch0 drops `in_valid` mid-packet while ch1 is valid.
  - Response: ch1 is not granted until ch0's last flit is accepted.
- Reset mid-packet:
  - Stimulus: assert `rst_n = 0` asynchronously after flit 1 of 3.
  - Response: outputs are 0 immediately; after release, ch1 can win from `rr_ptr = 0` (IDLE).
